fb_writer: RTL

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_writer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fb_writer.sv
// fb_writer -- framebuffer pixel writer with optional rectangle fill engine.
//
// Single-pixel writes arrive on a valid/ready handshake. In-range pixels are
// queued in a 4-entry FIFO and written to the framebuffer one per cycle
// whenever the scan-out reader leaves the memory port free (rd_busy low).
// Off-screen pixels are accepted and silently discarded.
//
// Optional feature (macro FB_FILL_EN): a rectangle fill engine. A fill
// command first lets the pixel FIFO drain, then writes every pixel of the
// clamped, inclusive rectangle in raster order, one per free cycle.
// Without FB_FILL_EN the fill ports exist but are ignored.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   px_valid/px_ready            pixel-write handshake
//   px_x, px_y, px_color         pixel coordinate and RGB444 colour
//   fill_start, fill_x0..y1      rectangle fill command, corners inclusive
//   fill_color                   rectangle colour (RGB444)
//   rd_busy                      scan-out reader owns the memory port
//   mem_wr, mem_addr, mem_wdata  registered framebuffer write port
//   busy                         accepted work still outstanding
module fb_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic [11:0] px_color,
  input  logic        fill_start,
  input  logic [9:0]  fill_x0,
  input  logic [9:0]  fill_y0,
  input  logic [9:0]  fill_x1,
  input  logic [9:0]  fill_y1,
  input  logic [11:0] fill_color,
  input  logic        rd_busy,
  output logic        mem_wr,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy
);

  localparam logic [18:0] WIDTH_19  = 19'(SCREEN_WIDTH);
  localparam logic [10:0] WIDTH_11  = 11'(SCREEN_WIDTH);
  localparam logic [10:0] HEIGHT_11 = 11'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  // Linear framebuffer address: one row is SCREEN_WIDTH words.
  function automatic logic [18:0] pixel_addr(input logic [9:0] x, input logic [9:0] y);
    return ({9'd0, y} * WIDTH_19) + {9'd0, x};
  endfunction

  state_t      state_q, state_d;
  logic [18:0] fifo_addr_q [4];
  logic [18:0] fifo_addr_d [4];
  logic [11:0] fifo_col_q [4];
  logic [11:0] fifo_col_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        mem_wr_q, mem_wr_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        px_ready_q, px_ready_d;
  logic        busy_q, busy_d;

  logic        in_range_s;
  logic        push_s;
  logic        pop_s;

`ifdef FB_FILL_EN
  localparam logic [9:0] X_MAX = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] Y_MAX = 10'(SCREEN_HEIGHT - 1);

  logic [9:0]  rx0_q, rx0_d, ry0_q, ry0_d;
  logic [9:0]  rx1_q, rx1_d, ry1_q, ry1_d;
  logic [11:0] rcol_q, rcol_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d;
`else
  // Fill inputs are intentionally ignored in this build.
  logic unused_fill_s;
  assign unused_fill_s = ^{fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color};
`endif

  // px_ready is registered, so a handshake only sees the post-edge state.
  assign in_range_s = ({1'b0, px_x} < WIDTH_11) && ({1'b0, px_y} < HEIGHT_11);
  assign push_s     = px_valid && px_ready_q && in_range_s;
  // The FIFO drains only while no fill is writing, so the two never collide.
  assign pop_s      = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) &&
                      !rd_busy && (count_q != 3'd0);

  // Next-state logic: FIFO, write port, fill engine and registered flags.
  always_comb begin
    state_d     = state_q;
    fifo_addr_d = fifo_addr_q;
    fifo_col_d  = fifo_col_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef FB_FILL_EN
    rx0_d  = rx0_q;
    ry0_d  = ry0_q;
    rx1_d  = rx1_q;
    ry1_d  = ry1_q;
    rcol_d = rcol_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
`endif

    if (push_s) begin
      fifo_addr_d[wr_ptr_q] = pixel_addr(px_x, px_y);
      fifo_col_d[wr_ptr_q]  = px_color;
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      mem_wr_d    = 1'b1;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = {4'h0, fifo_col_q[rd_ptr_q]};
      rd_ptr_d    = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

`ifdef FB_FILL_EN
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          rx0_d   = fill_x0;
          ry0_d   = fill_y0;
          rx1_d   = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
          ry1_d   = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
          rcol_d  = fill_color;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // An empty rectangle (after clamping) is abandoned without writes.
        if ((rx0_q > rx1_q) || (ry0_q > ry1_q)) begin
          state_d = ST_IDLE;
        end else if ((count_q == 3'd0) && !mem_wr_q) begin
          cx_d    = rx0_q;
          cy_d    = ry0_q;
          state_d = ST_FILL;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FILL: begin
        if (!rd_busy) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = pixel_addr(cx_q, cy_q);
          mem_wdata_d = {4'h0, rcol_q};
          if (cx_q == rx1_q) begin
            if (cy_q == ry1_q) begin
              state_d = ST_IDLE;
            end else begin
              cx_d = rx0_q;
              cy_d = cy_q + 10'd1;
            end
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    state_d = ST_IDLE;
`endif

    // Flags are registered copies of their definitions on the next state.
    px_ready_d = (count_d != 3'd4) && (state_d == ST_IDLE);
`ifdef FB_FILL_EN
    busy_d = (state_d != ST_IDLE) || (count_d != 3'd0) || mem_wr_d;
`else
    busy_d = (count_d != 3'd0) || mem_wr_d;
`endif
  end

  // State, FIFO and output registers; reset aborts all queued work.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        fifo_addr_q[i] <= 19'd0;
        fifo_col_q[i]  <= 12'd0;
      end
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 19'd0;
      mem_wdata_q <= 16'd0;
      px_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_col_q  <= fifo_col_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      px_ready_q  <= px_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef FB_FILL_EN
  // Latched rectangle and raster counters of the fill engine.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx0_q  <= 10'd0;
      ry0_q  <= 10'd0;
      rx1_q  <= 10'd0;
      ry1_q  <= 10'd0;
      rcol_q <= 12'd0;
      cx_q   <= 10'd0;
      cy_q   <= 10'd0;
    end else begin
      rx0_q  <= rx0_d;
      ry0_q  <= ry0_d;
      rx1_q  <= rx1_d;
      ry1_q  <= ry1_d;
      rcol_q <= rcol_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
    end
  end
`endif

  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign px_ready  = px_ready_q;
  assign busy      = busy_q;

endmodule
